// File: rtl/uart_tx_fifo_if.sv
// Core-side write port and line-side status of the buffered UART transmitter.
// The master modport is the MMIO store path; the slave modport is the transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          i_Tx_DV;
  logic [DATA_BITS-1:0]          i_Tx_Byte;
  logic                          o_Tx_Ready;
  logic                          o_Tx_Overflow;
  logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count;
  logic                          o_Tx_Active;
  logic                          o_Tx_Serial;
  logic                          o_Tx_Done;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Overflow, o_Fifo_Count, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Overflow, o_Fifo_Count, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter (configurable data/parity/stop) fed by a small write FIFO.
// Frames leave back-to-back while the FIFO holds data; writes to a full FIFO drop and flag overflow.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 260,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           i_Clock,
  input  logic           i_Rst_n,
  uart_tx_fifo_if.slave  bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 ovf_q;
  logic                 push, pop, full;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 active_q, active_d;
  logic                 serial_q, serial_d;
  logic                 done, load, bit_end;
  logic [DATA_BITS-1:0] head;

  assign full = (occ_q == OCC_FULL);
  assign push = bus.i_Tx_DV && !full;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Payload storage is not reset; the pointers and occupancy define validity.
  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_Tx_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_d;
      ovf_q <= bus.i_Tx_DV && full;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    par_d    = par_q;
    active_d = active_q;
    pop      = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    bit_end  = (cnt_q == CNT_LAST);
    cnt_d    = bit_end ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        load  = (occ_q != '0);
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            done = 1'b1;
            if (occ_q != '0) begin
              load = 1'b1;
            end else begin
              state_d  = S_IDLE;
              active_d = 1'b0;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        active_d = 1'b0;
        cnt_d    = '0;
      end
    endcase

    // Loading from STOP gives the zero-gap hand-off into the next frame.
    if (load) begin
      pop      = 1'b1;
      shift_d  = head;
      par_d    = (PARITY == 2) ? ^head : ~^head;
      active_d = 1'b1;
      state_d  = S_START;
      cnt_d    = '0;
    end

    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = par_d;
      default:  serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      active_q <= 1'b0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      active_q <= active_d;
      serial_q <= serial_d;
    end
  end

  assign bus.o_Tx_Ready    = !full;
  assign bus.o_Tx_Overflow = ovf_q;
  assign bus.o_Fifo_Count  = occ_q;
  assign bus.o_Tx_Active   = active_q;
  assign bus.o_Tx_Serial   = serial_q;
  assign bus.o_Tx_Done     = done;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, even/odd parity, 7-data/2-stop, bursts, overflow, mid-frame reset.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_dv = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  int         sel = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         t = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if0 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if1 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if2 ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if3 ();

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_8n1 (.i_Clock(clk), .i_Rst_n(rst_n), .bus(if0.slave));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_8e1 (.i_Clock(clk), .i_Rst_n(rst_n), .bus(if1.slave));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_8o1 (.i_Clock(clk), .i_Rst_n(rst_n), .bus(if2.slave));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_7n2 (.i_Clock(clk), .i_Rst_n(rst_n), .bus(if3.slave));

  assign if0.i_Tx_DV = wr_dv && (sel == 0);
  assign if1.i_Tx_DV = wr_dv && (sel == 1);
  assign if2.i_Tx_DV = wr_dv && (sel == 2);
  assign if3.i_Tx_DV = wr_dv && (sel == 3);
  assign if0.i_Tx_Byte = wr_byte;
  assign if1.i_Tx_Byte = wr_byte;
  assign if2.i_Tx_Byte = wr_byte;
  assign if3.i_Tx_Byte = wr_byte[6:0];

  logic       s_serial, s_active, s_done, s_ready, s_ovf;
  logic [2:0] s_count;

  always_comb begin
    s_serial = if0.o_Tx_Serial; s_active = if0.o_Tx_Active; s_done = if0.o_Tx_Done;
    s_ready  = if0.o_Tx_Ready;  s_ovf    = if0.o_Tx_Overflow; s_count = if0.o_Fifo_Count;
    case (sel)
      1: begin
        s_serial = if1.o_Tx_Serial; s_active = if1.o_Tx_Active; s_done = if1.o_Tx_Done;
        s_ready  = if1.o_Tx_Ready;  s_ovf    = if1.o_Tx_Overflow; s_count = if1.o_Fifo_Count;
      end
      2: begin
        s_serial = if2.o_Tx_Serial; s_active = if2.o_Tx_Active; s_done = if2.o_Tx_Done;
        s_ready  = if2.o_Tx_Ready;  s_ovf    = if2.o_Tx_Overflow; s_count = if2.o_Fifo_Count;
      end
      3: begin
        s_serial = if3.o_Tx_Serial; s_active = if3.o_Tx_Active; s_done = if3.o_Tx_Done;
        s_ready  = if3.o_Tx_Ready;  s_ovf    = if3.o_Tx_Overflow; s_count = if3.o_Fifo_Count;
      end
      default: ;
    endcase
  end

  logic       ser_a [256];
  logic       act_a [256];
  logic       dn_a  [256];
  logic       rdy_a [256];
  logic       ovf_a [256];
  logic [2:0] cnt_a [256];

  // Advance to the next falling edge and record the selected instance's outputs at index t.
  task automatic cyc();
    @(negedge clk);
    if (t < 256) begin
      ser_a[t] = s_serial; act_a[t] = s_active; dn_a[t] = s_done;
      rdy_a[t] = s_ready;  ovf_a[t] = s_ovf;    cnt_a[t] = s_count;
    end
    t++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sum1(input logic arr [256], input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) if (arr[i] === 1'b1) s++;
    return s;
  endfunction

  // Each line bit must hold for exactly four samples; fr[0] is the start bit.
  task automatic chk_frame(input string tag, input int st, input int nb, input logic [15:0] fr);
    logic [3:0] v;
    for (int b = 0; b < nb; b++) begin
      v = {ser_a[st + 4*b + 3], ser_a[st + 4*b + 2], ser_a[st + 4*b + 1], ser_a[st + 4*b]};
      chk($sformatf("%s line bit %0d", tag, b), {28'd0, v}, {28'd0, {4{fr[b]}}});
    end
  endtask

  task automatic run_single(input string tag, input int s, input logic [7:0] d,
                            input int nb, input logic [15:0] fr);
    int len;
    len = nb * 4;
    sel = s;
    t = 0;
    cyc();
    wr_byte = d; wr_dv = 1'b1;
    cyc();
    wr_dv = 1'b0;
    repeat (len + 2) cyc();
    chk({tag, " count after write"}, {29'd0, cnt_a[1]}, 32'd1);
    chk({tag, " idle before pop"}, {31'd0, act_a[1]}, 32'd0);
    chk_frame(tag, 2, nb, fr);
    chk({tag, " active clocks"}, sum1(act_a, 0, len + 3), len);
    chk({tag, " done pulses"}, sum1(dn_a, 0, len + 3), 1);
    chk({tag, " done on last clock"}, {31'd0, dn_a[len + 1]}, 32'd1);
    chk({tag, " active drops"}, {31'd0, act_a[len + 2]}, 32'd0);
    chk({tag, " line idle after"}, {31'd0, ser_a[len + 2]}, 32'd1);
  endtask

  logic [7:0]  w4 [6];
  logic [15:0] f4 [5];

  initial begin
    w4 = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hC3, 8'hFF};
    f4 = '{16'h302, 16'h284, 16'h248, 16'h230, 16'h386};

    // Reset state of every instance
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      chk($sformatf("rst%0d serial", s), {31'd0, s_serial}, 32'd1);
      chk($sformatf("rst%0d active", s), {31'd0, s_active}, 32'd0);
      chk($sformatf("rst%0d done", s),   {31'd0, s_done},   32'd0);
      chk($sformatf("rst%0d ovf", s),    {31'd0, s_ovf},    32'd0);
      chk($sformatf("rst%0d count", s),  {29'd0, s_count},  32'd0);
      chk($sformatf("rst%0d ready", s),  {31'd0, s_ready},  32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_single("8N1 A5", 0, 8'hA5, 10, 16'h34A);
    run_single("8E1 07", 1, 8'h07, 11, 16'h60E);
    run_single("8O1 07", 2, 8'h07, 11, 16'h40E);
    run_single("7N2 7F", 3, 8'h7F, 10, 16'h3FE);

    // Three consecutive writes: frames must abut
    sel = 0; t = 0;
    cyc(); wr_byte = 8'h11; wr_dv = 1'b1;
    cyc(); wr_byte = 8'h22;
    cyc(); wr_byte = 8'h33;
    cyc(); wr_dv = 1'b0;
    repeat (122) cyc();
    chk("burst count", {29'd0, cnt_a[3]}, 32'd2);
    chk_frame("burst f1", 2, 10, 16'h222);
    chk_frame("burst f2", 42, 10, 16'h244);
    chk_frame("burst f3", 82, 10, 16'h266);
    chk("burst active clocks", sum1(act_a, 0, 125), 120);
    chk("burst active end", {31'd0, act_a[122]}, 32'd0);
    chk("burst done count", sum1(dn_a, 0, 125), 3);
    chk("burst done1", {31'd0, dn_a[41]}, 32'd1);
    chk("burst done2", {31'd0, dn_a[81]}, 32'd1);
    chk("burst done3", {31'd0, dn_a[121]}, 32'd1);

    // Six writes into a four-deep FIFO: sixth one drops
    sel = 0; t = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(); wr_byte = w4[i]; wr_dv = 1'b1;
    end
    cyc(); wr_dv = 1'b0;
    repeat (200) cyc();
    chk("ovf count after pop", {29'd0, cnt_a[2]}, 32'd1);
    chk("ovf ready at 3", {31'd0, rdy_a[4]}, 32'd1);
    chk("ovf count full", {29'd0, cnt_a[5]}, 32'd4);
    chk("ovf ready full", {31'd0, rdy_a[5]}, 32'd0);
    chk("ovf no early pulse", {31'd0, ovf_a[5]}, 32'd0);
    chk("ovf pulse", {31'd0, ovf_a[6]}, 32'd1);
    chk("ovf pulse width", sum1(ovf_a, 0, 206), 1);
    chk("ovf count held", {29'd0, cnt_a[6]}, 32'd4);
    chk("ovf count after 2nd pop", {29'd0, cnt_a[42]}, 32'd3);
    chk("ovf ready after 2nd pop", {31'd0, rdy_a[42]}, 32'd1);
    for (int i = 0; i < 5; i++) chk_frame($sformatf("ovf word%0d", i + 1), 2 + 40*i, 10, f4[i]);
    chk("ovf done count", sum1(dn_a, 0, 206), 5);
    chk("ovf active end", {31'd0, act_a[202]}, 32'd0);
    chk("ovf fifo empty", {29'd0, cnt_a[203]}, 32'd0);

    // Reset asserted during data bit 3 of a frame with a word still queued
    sel = 0; t = 0;
    cyc(); wr_byte = 8'h00; wr_dv = 1'b1;
    cyc(); wr_byte = 8'hFF;
    cyc(); wr_dv = 1'b0;
    repeat (17) cyc();
    chk("abort pre serial", {31'd0, ser_a[19]}, 32'd0);
    chk("abort pre active", {31'd0, act_a[19]}, 32'd1);
    chk("abort pre count", {29'd0, cnt_a[19]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort serial", {31'd0, s_serial}, 32'd1);
    chk("abort active", {31'd0, s_active}, 32'd0);
    chk("abort count", {29'd0, s_count}, 32'd0);
    chk("abort done", {31'd0, s_done}, 32'd0);
    t = 0;
    cyc();
    rst_n = 1'b1;
    repeat (12) cyc();
    chk("abort no done", sum1(dn_a, 0, 12), 0);
    chk("abort stays idle", sum1(act_a, 0, 12), 0);
    chk("abort line high", sum1(ser_a, 0, 12), 13);
    chk("abort fifo empty", {29'd0, cnt_a[12]}, 32'd0);
    chk("abort ready", {31'd0, rdy_a[12]}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
